bfm_ahb2_arbiter: RTL and testbench

Two-master AHB-lite arbiter that shares one AHB slave port (the AHB-to-APB bridge BFM) between two AHB-lite requesters in the BFM testbench fabric. Each master's address phase is captured locally and the master is wait-stated until the transfer has been replayed on the shared port and completed. Grants are round-robin per transfer, with optional HMASTLOCK sequence holding.

---
 rtl/bfm_ahb2_arb_pkg.sv | 21 ++
 rtl/bfm_ahb2_arb_capture.sv | 45 ++++
 rtl/bfm_ahb2_arbiter.sv | 140 ++++++++++++++
 tb/tb_bfm_ahb2_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bfm_ahb2_arb_pkg.sv
// bfm_ahb2_arb_pkg: shared types and constants for the two-master AHB-lite arbiter
//   arb_state_e   : arbiter FSM states (IDLE, ADDR, DATA)
//   HTRANS_*      : AHB transfer type encodings
//   arb_cap_t     : captured address-phase record (addr, write, size, lock)
//   htrans_active : true for transfer types that get captured (NONSEQ, SEQ)
package bfm_ahb2_arb_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} arb_state_e;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic        lock;
   } arb_cap_t;
   function automatic logic htrans_active(input logic [1:0] t);
      return t == HTRANS_NONSEQ || t == HTRANS_SEQ;
   endfunction
endpackage

// File: rtl/bfm_ahb2_arb_capture.sv
// bfm_ahb2_arb_capture: per-master address-phase capture, pend flag and HREADY/HRESP
//   hclk_i, hresetn_i       : clock, async active-low reset
//   htrans_i..hmastlock_i   : master address phase
//   sel_i                   : this master owns the shared data phase
//   s_hreadyout_i, s_hresp_i: shared slave response
//   hready_o, hresp_o       : master response
//   pend_o, cap_o           : pending flag and captured record
module bfm_ahb2_arb_capture
   import bfm_ahb2_arb_pkg::*;
(
   input  logic        hclk_i,
   input  logic        hresetn_i,
   input  logic [1:0]  htrans_i,
   input  logic [31:0] haddr_i,
   input  logic        hwrite_i,
   input  logic [2:0]  hsize_i,
   input  logic        hmastlock_i,
   input  logic        sel_i,
   input  logic        s_hreadyout_i,
   input  logic        s_hresp_i,
   output logic        hready_o,
   output logic        hresp_o,
   output logic        pend_o,
   output arb_cap_t    cap_o
);
   logic     pend_q, pend_d, take, done;
   arb_cap_t cap_q, cap_d;
   assign done     = sel_i & s_hreadyout_i;
   assign hready_o = ~pend_q | done;
   assign hresp_o  = sel_i & s_hresp_i;
   assign take     = hready_o & htrans_active(htrans_i);
   // a capture on the completing cycle keeps pend set with the new request
   assign pend_d   = take | (pend_q & ~done);
   assign cap_d    = take ? {haddr_i, hwrite_i, hsize_i, hmastlock_i} : cap_q;
   assign pend_o   = pend_q;
   assign cap_o    = cap_q;
   always_ff @(posedge hclk_i or negedge hresetn_i)
      if (!hresetn_i) begin
         pend_q <= 1'b0;
         cap_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cap_q  <= cap_d;
      end
endmodule

// File: rtl/bfm_ahb2_arbiter.sv
// bfm_ahb2_arbiter: two-master AHB-lite arbiter sharing one slave port, round-robin per transfer
//   HCLK, HRESETN            : clock, async active-low reset
//   Mx_H* (x=0,1)            : master ports; address phase captured, master wait-stated until replayed
//   S_H*                     : shared slave port
//   ARB_MASTLOCK_EN (macro)  : when defined, HMASTLOCK sequences hold the grant for the lock owner;
//                              when undefined HMASTLOCK is ignored and S_HMASTLOCK=0
module bfm_ahb2_arbiter
   import bfm_ahb2_arb_pkg::*;
(
   input  logic        HCLK,
   input  logic        HRESETN,
   input  logic [1:0]  M0_HTRANS,
   input  logic [31:0] M0_HADDR,
   input  logic        M0_HWRITE,
   input  logic [2:0]  M0_HSIZE,
   input  logic        M0_HMASTLOCK,
   input  logic [31:0] M0_HWDATA,
   output logic        M0_HREADY,
   output logic        M0_HRESP,
   output logic [31:0] M0_HRDATA,
   input  logic [1:0]  M1_HTRANS,
   input  logic [31:0] M1_HADDR,
   input  logic        M1_HWRITE,
   input  logic [2:0]  M1_HSIZE,
   input  logic        M1_HMASTLOCK,
   input  logic [31:0] M1_HWDATA,
   output logic        M1_HREADY,
   output logic        M1_HRESP,
   output logic [31:0] M1_HRDATA,
   output logic        S_HSEL,
   output logic        S_HWRITE,
   output logic        S_HMASTLOCK,
   output logic [1:0]  S_HTRANS,
   output logic [31:0] S_HADDR,
   output logic [2:0]  S_HSIZE,
   output logic [31:0] S_HWDATA,
   output logic        S_HREADYIN,
   input  logic        S_HREADYOUT,
   input  logic        S_HRESP,
   input  logic [31:0] S_HRDATA
);
   arb_state_e  state_q;
   logic        grant_q, last_grant_q;
   logic [31:0] s_addr_q;
   logic        s_write_q, s_lock_q;
   logic [2:0]  s_size_q;
   arb_cap_t    cap [2];
   logic [1:0]  pend;
   logic        in_data, done, rr_pick, pick, pick_ok, lock_d, load, nxt_sel;

   assign in_data = state_q == ST_DATA;
   assign done    = in_data & S_HREADYOUT;

   bfm_ahb2_arb_capture u_cap0 (
      .hclk_i(HCLK), .hresetn_i(HRESETN),
      .htrans_i(M0_HTRANS), .haddr_i(M0_HADDR), .hwrite_i(M0_HWRITE),
      .hsize_i(M0_HSIZE), .hmastlock_i(M0_HMASTLOCK),
      .sel_i(in_data & ~grant_q), .s_hreadyout_i(S_HREADYOUT), .s_hresp_i(S_HRESP),
      .hready_o(M0_HREADY), .hresp_o(M0_HRESP), .pend_o(pend[0]), .cap_o(cap[0])
   );

   bfm_ahb2_arb_capture u_cap1 (
      .hclk_i(HCLK), .hresetn_i(HRESETN),
      .htrans_i(M1_HTRANS), .haddr_i(M1_HADDR), .hwrite_i(M1_HWRITE),
      .hsize_i(M1_HSIZE), .hmastlock_i(M1_HMASTLOCK),
      .sel_i(in_data & grant_q), .s_hreadyout_i(S_HREADYOUT), .s_hresp_i(S_HRESP),
      .hready_o(M1_HREADY), .hresp_o(M1_HRESP), .pend_o(pend[1]), .cap_o(cap[1])
   );

   // tie goes to the master that was not served last
   assign rr_pick = &pend ? ~last_grant_q : pend[1];

`ifdef ARB_MASTLOCK_EN
   logic lock_q, owner_q, owner_d, owner_idle;
   assign owner_idle = owner_q ? (M1_HTRANS == HTRANS_IDLE && M1_HREADY)
                               : (M0_HTRANS == HTRANS_IDLE && M0_HREADY);
   always_comb begin
      lock_d  = lock_q;
      owner_d = owner_q;
      if (state_q == ST_IDLE && pick_ok && cap[pick].lock) begin
         lock_d  = 1'b1;
         owner_d = pick;
      end
      if (lock_q && ((done && !cap[grant_q].lock) || owner_idle))
         lock_d = 1'b0;
   end
   always_ff @(posedge HCLK or negedge HRESETN)
      if (!HRESETN) begin
         lock_q  <= 1'b0;
         owner_q <= 1'b0;
      end else begin
         lock_q  <= lock_d;
         owner_q <= owner_d;
      end
   // a held lock restricts the grant decision to the owner
   assign pick        = lock_q ? owner_q : rr_pick;
   assign pick_ok     = lock_q ? pend[owner_q] : |pend;
   assign S_HMASTLOCK = state_q == ST_ADDR && s_lock_q;
`else
   logic unused_lock;
   assign lock_d      = 1'b0;
   assign pick        = rr_pick;
   assign pick_ok     = |pend;
   assign S_HMASTLOCK = 1'b0;
   assign unused_lock = ^{cap[0].lock, cap[1].lock, s_lock_q};
`endif

   // a completion hands straight over only to the other master; a same-master
   // re-capture waits for the next IDLE decision
   assign load    = (state_q == ST_IDLE && pick_ok) || (done && pend[~grant_q] && !lock_d);
   assign nxt_sel = state_q == ST_IDLE ? pick : ~grant_q;

   always_ff @(posedge HCLK or negedge HRESETN)
      if (!HRESETN) begin
         state_q      <= ST_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         s_addr_q     <= '0;
         s_write_q    <= 1'b0;
         s_size_q     <= '0;
         s_lock_q     <= 1'b0;
      end else begin
         state_q <= load ? ST_ADDR : state_q == ST_ADDR ? ST_DATA : done ? ST_IDLE : state_q;
         if (load) begin
            grant_q <= nxt_sel;
            {s_addr_q, s_write_q, s_size_q, s_lock_q} <= cap[nxt_sel];
         end
         if (done) last_grant_q <= grant_q;
      end

   assign S_HSEL     = state_q == ST_ADDR;
   assign S_HTRANS   = S_HSEL ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign S_HADDR    = s_addr_q;
   assign S_HWRITE   = s_write_q;
   assign S_HSIZE    = s_size_q;
   assign S_HWDATA   = in_data ? (grant_q ? M1_HWDATA : M0_HWDATA) : '0;
   assign S_HREADYIN = in_data ? S_HREADYOUT : 1'b1;
   assign M0_HRDATA  = S_HRDATA;
   assign M1_HRDATA  = S_HRDATA;
endmodule

// File: tb/tb_bfm_ahb2_arbiter.sv
// tb_bfm_ahb2_arbiter: directed self-checking bench for bfm_ahb2_arbiter
module tb_bfm_ahb2_arbiter;
   logic        HCLK = 1'b0, HRESETN = 1'b0;
   logic [1:0]  M0_HTRANS, M1_HTRANS, S_HTRANS;
   logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, M0_HRDATA, M1_HRDATA;
   logic        M0_HWRITE, M1_HWRITE, M0_HMASTLOCK, M1_HMASTLOCK;
   logic [2:0]  M0_HSIZE, M1_HSIZE, S_HSIZE;
   logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
   logic        S_HSEL, S_HWRITE, S_HMASTLOCK, S_HREADYIN, S_HREADYOUT, S_HRESP;
   logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
   int          vectors = 0, miscompares = 0;
   logic [31:0] aphase [$];
   localparam logic [1:0] IDL = 2'b00, NSQ = 2'b10;

   bfm_ahb2_arbiter dut (
      .HCLK(HCLK), .HRESETN(HRESETN),
      .M0_HTRANS(M0_HTRANS), .M0_HADDR(M0_HADDR), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
      .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY),
      .M0_HRESP(M0_HRESP), .M0_HRDATA(M0_HRDATA),
      .M1_HTRANS(M1_HTRANS), .M1_HADDR(M1_HADDR), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
      .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY),
      .M1_HRESP(M1_HRESP), .M1_HRDATA(M1_HRDATA),
      .S_HSEL(S_HSEL), .S_HWRITE(S_HWRITE), .S_HMASTLOCK(S_HMASTLOCK), .S_HTRANS(S_HTRANS),
      .S_HADDR(S_HADDR), .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HREADYIN(S_HREADYIN),
      .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA)
   );

   always #5 HCLK = ~HCLK;

   always @(negedge HCLK)
      if (S_HSEL && S_HTRANS == NSQ) aphase.push_back(S_HADDR);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic m0(input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
      M0_HTRANS = t; M0_HADDR = a; M0_HWRITE = w; M0_HSIZE = 3'd2; M0_HMASTLOCK = l;
   endtask

   task automatic m1(input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
      M1_HTRANS = t; M1_HADDR = a; M1_HWRITE = w; M1_HSIZE = 3'd2; M1_HMASTLOCK = l;
   endtask

   task automatic tie(input logic [31:0] a0, input logic [31:0] a1, input logic m1_first);
      logic [31:0] fa, sa;
      fa = m1_first ? a1 : a0;
      sa = m1_first ? a0 : a1;
      m0(NSQ, a0, 1'b0, 1'b0); m1(NSQ, a1, 1'b0, 1'b0);
      tick(); m0(IDL, '0, 1'b0, 1'b0); m1(IDL, '0, 1'b0, 1'b0); #1;
      check("tie_m0_wait", M0_HREADY, 0);
      check("tie_m1_wait", M1_HREADY, 0);
      tick(); #1;
      check("tie_first_addr", S_HADDR, fa);
      check("tie_first_sel", S_HSEL, 1);
      tick(); S_HRDATA = ~fa; #1;
      check("tie_first_m0_rdy", M0_HREADY, !m1_first);
      check("tie_first_m1_rdy", M1_HREADY, m1_first);
      check("tie_first_rdata", m1_first ? M1_HRDATA : M0_HRDATA, ~fa);
      tick(); #1;
      check("tie_second_addr", S_HADDR, sa);
      tick(); S_HRDATA = ~sa; #1;
      check("tie_second_m0_rdy", M0_HREADY, 1);
      check("tie_second_m1_rdy", M1_HREADY, 1);
      check("tie_second_rdata", m1_first ? M0_HRDATA : M1_HRDATA, ~sa);
      tick();
   endtask

   initial begin
      int lows, left0, left1, n0;
      logic cap0, cap1;
      logic [31:0] exp_ord [4];
      m0(IDL, '0, 1'b0, 1'b0); m1(IDL, '0, 1'b0, 1'b0);
      M0_HWDATA = '0; M1_HWDATA = '0;
      S_HREADYOUT = 1'b1; S_HRESP = 1'b0; S_HRDATA = '0;
      repeat (2) tick();
      #1;
      check("rst_m0_hready", M0_HREADY, 1);
      check("rst_m1_hready", M1_HREADY, 1);
      check("rst_m0_hresp", M0_HRESP, 0);
      check("rst_hsel", S_HSEL, 0);
      check("rst_htrans", S_HTRANS, 0);
      check("rst_haddr", S_HADDR, 0);
      check("rst_hwdata", S_HWDATA, 0);
      check("rst_hreadyin", S_HREADYIN, 1);
      check("rst_hmastlock", S_HMASTLOCK, 0);
      HRESETN = 1'b1;

      // simultaneous reads: M0 wins the first tie after reset
      tie(32'h2000_0000, 32'h3000_0000, 1'b0);

      // zero-wait M0 write
      m0(NSQ, 32'h1000_0004, 1'b1, 1'b0); #1;
      check("wr_m0_rdy_addr", M0_HREADY, 1);
      tick(); m0(IDL, '0, 1'b0, 1'b0); M0_HWDATA = 32'hDEAD_BEEF; #1;
      check("wr_wait1", M0_HREADY, 0);
      tick(); #1;
      check("wr_wait2", M0_HREADY, 0);
      check("wr_s_haddr", S_HADDR, 32'h1000_0004);
      check("wr_s_hwrite", S_HWRITE, 1);
      check("wr_s_htrans", S_HTRANS, 2);
      check("wr_s_hsize", S_HSIZE, 2);
      tick(); #1;
      check("wr_s_hwdata", S_HWDATA, 32'hDEAD_BEEF);
      check("wr_m0_done", M0_HREADY, 1);
      check("wr_data_htrans", S_HTRANS, 0);
      tick(); #1;
      check("wr_idle_hwdata", S_HWDATA, 0);
      check("wr_idle_haddr_hold", S_HADDR, 32'h1000_0004);
      check("wr_idle_hwrite_hold", S_HWRITE, 1);

      // M0 was served last: the next tie goes to M1
      tie(32'h2000_0010, 32'h3000_0010, 1'b1);

      // M1 read with 3 slave wait states; M0 arrives meanwhile
      m1(NSQ, 32'h3000_0040, 1'b0, 1'b0);
      lows = 0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 1) m1(IDL, '0, 1'b0, 1'b0);
         if (c == 2) m0(NSQ, 32'h2000_0080, 1'b0, 1'b0);
         if (c == 3) m0(IDL, '0, 1'b0, 1'b0);
         S_HREADYOUT = !(c >= 3 && c <= 5);
         S_HRDATA = 32'h0BAD_F00D;
         #1;
         if (M1_HREADY) break;
         lows++;
      end
      check("ws_m1_low_cycles", lows, 5);
      check("ws_m1_rdata", M1_HRDATA, 32'h0BAD_F00D);
      check("ws_m0_waiting", M0_HREADY, 0);
      tick(); #1;
      check("ws_m0_granted_addr", S_HADDR, 32'h2000_0080);
      check("ws_m0_granted_sel", S_HSEL, 1);
      tick(); #1;
      check("ws_m0_done", M0_HREADY, 1);
      tick();

      // two-cycle error on an M0 write
      m0(NSQ, 32'h4000_1000, 1'b1, 1'b0);
      tick(); m0(IDL, '0, 1'b0, 1'b0); M0_HWDATA = 32'hCAFE_0001;
      tick();
      tick(); S_HREADYOUT = 1'b0; S_HRESP = 1'b1; #1;
      check("err1_m0_hresp", M0_HRESP, 1);
      check("err1_m0_hready", M0_HREADY, 0);
      check("err1_m1_hresp", M1_HRESP, 0);
      check("err1_m1_hready", M1_HREADY, 1);
      tick(); S_HREADYOUT = 1'b1; #1;
      check("err2_m0_hresp", M0_HRESP, 1);
      check("err2_m0_hready", M0_HREADY, 1);
      check("err2_m1_hresp", M1_HRESP, 0);
      tick(); S_HRESP = 1'b0; #1;
      check("err_after_hresp", M0_HRESP, 0);

      // three locked M0 transfers while M1 becomes pending
`ifdef ARB_MASTLOCK_EN
      exp_ord = '{32'h4000_0000, 32'h4000_0010, 32'h4000_0020, 32'h5000_0000};
`else
      exp_ord = '{32'h4000_0000, 32'h5000_0000, 32'h4000_0010, 32'h4000_0020};
`endif
      left0 = 3; left1 = 0;
      n0 = aphase.size();
      for (int c = 0; c < 16; c++) begin
         if (c == 1) left1 = 1;
         m0(left0 != 0 ? NSQ : IDL, 32'h4000_0000 + 32'((3 - left0) * 16), 1'b0, left0 != 0);
         m1(left1 != 0 ? NSQ : IDL, 32'h5000_0000, 1'b0, 1'b0);
         #1;
         cap0 = M0_HREADY && left0 != 0;
         cap1 = M1_HREADY && left1 != 0;
         tick();
         if (cap0) left0--;
         if (cap1) left1--;
      end
      check("lk_addr_phases", 32'(aphase.size() - n0), 4);
      for (int i = 0; i < 4; i++)
         if (n0 + i < aphase.size()) check($sformatf("lk_order%0d", i), aphase[n0 + i], exp_ord[i]);

      // reset during a stalled data phase
      m0(NSQ, 32'h6000_0000, 1'b0, 1'b0);
      tick(); m0(IDL, '0, 1'b0, 1'b0);
      tick();
      tick(); S_HREADYOUT = 1'b0; #1;
      check("rstd_pre_readyin", S_HREADYIN, 0);
      check("rstd_pre_m0_hready", M0_HREADY, 0);
      HRESETN = 1'b0; #1;
      check("rstd_m0_hready", M0_HREADY, 1);
      check("rstd_hreadyin", S_HREADYIN, 1);
      check("rstd_haddr", S_HADDR, 0);
      check("rstd_hsel", S_HSEL, 0);
      check("rstd_htrans", S_HTRANS, 0);
      tick(); HRESETN = 1'b1; S_HREADYOUT = 1'b1;
      m1(NSQ, 32'h7000_0000, 1'b0, 1'b0);
      tick(); m1(IDL, '0, 1'b0, 1'b0); #1;
      check("post_rst_m1_wait", M1_HREADY, 0);
      tick(); #1;
      check("post_rst_addr", S_HADDR, 32'h7000_0000);
      tick(); S_HRDATA = 32'h1234_5678; #1;
      check("post_rst_m1_done", M1_HREADY, 1);
      check("post_rst_m1_rdata", M1_HRDATA, 32'h1234_5678);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
